avalon_multi_timer: RTL and testbench

//  Parametrised multi-channel interval timer; Avalon-MM slave on the Nios system bus.
//  NUM_CH independent CNT_W-bit down-counters, each with:
//   - period and snapshot registers; one-shot or continuous mode.
//   - per-channel timeout flag; combined and vectored interrupts.

---
 rtl/avalon_multi_timer.sv | 222 ++++++++++++++++++++++
 tb/tb_avalon_multi_timer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_multi_timer.sv
// avalon_multi_timer: multi-channel interval timer on an Avalon-MM slave port.
//
// NUM_CH independent CNT_W-bit down-counters. Each channel has a period, a snapshot, optional
// compare (PWM), one-shot or continuous mode, a sticky timeout flag and an interrupt enable.
//
// Build option: define TIMER_PWM_EN to add the per-channel COMPARE register at offset 4 and
// a registered PWM output. Without it, offset 4 reads 0 and pwm_out_o is tied to 0.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   address_i     word address; [ADDR_W-1:3] channel, [2:0] register offset
//   chipselect_i  slave select
//   write_n_i     active-low write strobe, qualified by chipselect_i
//   writedata_i   write data
//   readdata_o    registered read data, valid one clock after the address
//   irq_o         OR of irq_vec_o
//   irq_vec_o     per-channel interrupt (TO & ITO)
//   pwm_out_o     per-channel PWM output
//
// Register map per channel (stride of 8 words):
//   0 STATUS   bit0 TO, bit1 RUN (read-only); any write clears TO
//   1 CONTROL  bit0 ITO, bit1 CONT (stored); bit2 START, bit3 STOP (write-only strobes)
//   2 PERIOD   write forces a reload and stops the channel
//   3 SNAP     write latches the current count; read returns the latched value
//   4 COMPARE  PWM threshold (TIMER_PWM_EN builds only)
//   5-7        read 0, writes ignored
module avalon_multi_timer #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned RESET_PERIOD = 49999,
  localparam int unsigned ADDR_W      = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              chipselect_i,
  input  logic              write_n_i,
  input  logic [31:0]       writedata_i,
  output logic [31:0]       readdata_o,
  output logic              irq_o,
  output logic [NUM_CH-1:0] irq_vec_o,
  output logic [NUM_CH-1:0] pwm_out_o
);

  localparam logic [CNT_W-1:0] ResetPeriod = CNT_W'(RESET_PERIOD);

  // Address decode. Extending to 32 bits keeps the channel field well-formed even when
  // NUM_CH == 1 and the address carries no channel bits at all.
  logic [31:0] addr_ext;
  logic [28:0] ch_sel;
  logic [2:0]  offset;
  logic        wr_en;
  logic        rd_en;

  assign addr_ext = 32'(address_i);
  assign ch_sel   = addr_ext[31:3];
  assign offset   = addr_ext[2:0];
  assign wr_en    = chipselect_i & ~write_n_i;
  assign rd_en    = chipselect_i & write_n_i;

  logic [NUM_CH-1:0][31:0] ch_rdata;
  logic [NUM_CH-1:0]       ch_irq;
  logic [NUM_CH-1:0]       ch_pwm;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic             sel;
    logic             wr_status;
    logic             wr_ctrl;
    logic             wr_period;
    logic             wr_snap;
    logic             start;
    logic             stop;
    logic             cnt_zero;
    logic             to_event;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic             run_q, run_d;
    logic             to_q, to_d;
    logic             ito_q, ito_d;
    logic             cont_q, cont_d;
    logic             force_reload_q;
    logic             zero_q;
    logic [CNT_W-1:0] cmp_val;
    logic [31:0]      rdata;

    assign sel       = (ch_sel == 29'(c));
    assign wr_status = wr_en & sel & (offset == 3'd0);
    assign wr_ctrl   = wr_en & sel & (offset == 3'd1);
    assign wr_period = wr_en & sel & (offset == 3'd2);
    assign wr_snap   = wr_en & sel & (offset == 3'd3);
    assign start     = wr_ctrl & writedata_i[2];
    assign stop      = wr_ctrl & writedata_i[3];

    // Timeout is the rising edge of count==0, so a channel parked at zero (PERIOD=0 in
    // continuous mode) raises TO only once.
    assign cnt_zero  = (count_q == '0);
    assign to_event  = cnt_zero & ~zero_q;

    always_comb begin
      count_d = count_q;
      if (force_reload_q) begin
        count_d = period_q;
      end else if (run_q) begin
        count_d = cnt_zero ? period_q : count_q - CNT_W'(1);
      end

      // START has priority over every stop condition.
      run_d = run_q;
      if (start) begin
        run_d = 1'b1;
      end else if (stop || force_reload_q || (run_q && cnt_zero && !cont_q)) begin
        run_d = 1'b0;
      end

      // A timeout coinciding with a STATUS write wins so no event is lost.
      to_d = to_q;
      if (to_event) begin
        to_d = 1'b1;
      end else if (wr_status) begin
        to_d = 1'b0;
      end

      ito_d    = wr_ctrl   ? writedata_i[0]         : ito_q;
      cont_d   = wr_ctrl   ? writedata_i[1]         : cont_q;
      period_d = wr_period ? writedata_i[CNT_W-1:0] : period_q;
      snap_d   = wr_snap   ? count_q                : snap_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        count_q        <= ResetPeriod;
        period_q       <= ResetPeriod;
        snap_q         <= '0;
        run_q          <= 1'b0;
        to_q           <= 1'b0;
        ito_q          <= 1'b0;
        cont_q         <= 1'b0;
        force_reload_q <= 1'b0;
        zero_q         <= 1'b0;
      end else begin
        count_q        <= count_d;
        period_q       <= period_d;
        snap_q         <= snap_d;
        run_q          <= run_d;
        to_q           <= to_d;
        ito_q          <= ito_d;
        cont_q         <= cont_d;
        force_reload_q <= wr_period;
        zero_q         <= cnt_zero;
      end
    end

`ifdef TIMER_PWM_EN
    logic             wr_cmp;
    logic [CNT_W-1:0] compare_q;
    logic             pwm_q;

    assign wr_cmp = wr_en & sel & (offset == 3'd4);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        compare_q <= '0;
        pwm_q     <= 1'b0;
      end else begin
        if (wr_cmp) begin
          compare_q <= writedata_i[CNT_W-1:0];
        end
        pwm_q <= run_q & (count_q < compare_q);
      end
    end

    assign cmp_val   = compare_q;
    assign ch_pwm[c] = pwm_q;
`else
    assign cmp_val   = '0;
    assign ch_pwm[c] = 1'b0;
`endif

    always_comb begin
      rdata = '0;
      case (offset)
        3'd0:    rdata = {30'b0, run_q, to_q};
        3'd1:    rdata = {30'b0, cont_q, ito_q};
        3'd2:    rdata = 32'(period_q);
        3'd3:    rdata = 32'(snap_q);
        3'd4:    rdata = 32'(cmp_val);
        default: rdata = '0;
      endcase
    end

    assign ch_rdata[c] = rdata;
    assign ch_irq[c]   = to_q & ito_q;
  end

  // Registered read mux; unmatched channels (>= NUM_CH) fall through to 0.
  logic [31:0] readdata_d, readdata_q;

  always_comb begin
    readdata_d = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ch_sel == 29'(c)) begin
        readdata_d = ch_rdata[c];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= rd_en ? readdata_d : '0;
    end
  end

  assign readdata_o = readdata_q;
  assign irq_vec_o  = ch_irq;
  assign irq_o      = |ch_irq;
  assign pwm_out_o  = ch_pwm;

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Bench for avalon_multi_timer (default parameters). Reads push their expected value into a
// scoreboard queue; the returned readdata is queued alongside and each scenario task pops and
// compares the pairs. Non-bus outputs are compared inline. Inputs change on the falling edge.
module tb_avalon_multi_timer;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] irq_vec;
  logic [NUM_CH-1:0] pwm_out;

  avalon_multi_timer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address_i    (address),
    .chipselect_i (chipselect),
    .write_n_i    (write_n),
    .writedata_i  (writedata),
    .readdata_o   (readdata),
    .irq_o        (irq),
    .irq_vec_o    (irq_vec),
    .pwm_out_o    (pwm_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] got_q[$];
  int          checks = 0;
  int          errors = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required to finish earlier");
    $fatal(1);
  end

  // All bus tasks start and end on a falling edge.
  task automatic wr(input int ch, input int off, input logic [31:0] data);
    address    = ADDR_W'(ch * 8 + off);
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input int ch, input int off, input logic [31:0] exp, input string name);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    address    = ADDR_W'(ch * 8 + off);
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    got_q.push_back(readdata);
    chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    sb_t         e;
    logic [31:0] g;
    idle(2);
    checks++;
    if (irq !== 1'b0 || readdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: irq=%b readdata=%0d, required irq=0 readdata=0", irq, readdata);
    end
    chipselect = 1'b1;
    address    = ADDR_W'(2);
    idle(1);
    checks++;
    if (readdata !== 32'd0 || irq_vec !== '0 || pwm_out !== '0) begin
      errors++;
      $display("FAIL reset_read_held: readdata=%0d irq_vec=%b pwm=%b, required all 0",
               readdata, irq_vec, pwm_out);
    end
    chipselect = 1'b0;
    reset_n    = 1'b1;
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      rd(ch, 0, 32'd0, "reset_status");
      rd(ch, 2, 32'd49999, "reset_period");
      rd(ch, 1, 32'd0, "reset_control");
      rd(ch, 3, 32'd0, "reset_snap");
    end
    rd(2, 4, 32'd0, "reset_compare");
    rd(1, 6, 32'd0, "reserved_offset");
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq_after: irq=%b, required 0", irq);
    end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0d, required %0d", e.name, g, e.exp);
      end
    end
  endtask

  task automatic test_oneshot();
    sb_t         e;
    logic [31:0] g;
    wr(1, 2, 32'd5);
    wr(1, 1, 32'h5);
    // Counts 5..0 with RUN=1, then TO with RUN=0.
    for (int i = 0; i < 7; i++) begin
      rd(1, 0, (i < 6) ? 32'd2 : 32'd1, "oneshot_status");
      checks++;
      if (irq !== (i >= 5)) begin
        errors++;
        $display("FAIL oneshot_irq[%0d]: irq=%b, required %b", i, irq, (i >= 5));
      end
    end
    checks++;
    if (irq_vec !== 4'b0010) begin
      errors++;
      $display("FAIL oneshot_irq_vec: got %b, required 0010", irq_vec);
    end
    wr(1, 0, 32'd0);
    checks++;
    if (irq !== 1'b0 || irq_vec !== 4'b0000) begin
      errors++;
      $display("FAIL oneshot_clear: irq=%b irq_vec=%b, required 0/0000", irq, irq_vec);
    end
    rd(1, 0, 32'd0, "oneshot_status_cleared");
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0d, required %0d", e.name, g, e.exp);
      end
    end
  endtask

  task automatic test_continuous();
    sb_t         e;
    logic [31:0] g;
    wr(0, 2, 32'd3);
    wr(0, 1, 32'h6);
    for (int i = 0; i < 5; i++) begin
      rd(0, 0, (i < 4) ? 32'd2 : 32'd3, "cont_first_event");
    end
    wr(0, 0, 32'd0);
    rd(0, 0, 32'd2, "cont_cleared");
    rd(0, 0, 32'd2, "cont_cleared");
    rd(0, 0, 32'd3, "cont_second_event");
    wr(0, 1, 32'h8);
    rd(0, 0, 32'd1, "cont_stopped");
    wr(0, 3, 32'd0);
    rd(0, 3, 32'd1, "cont_snap");
    idle(5);
    wr(0, 3, 32'd0);
    rd(0, 3, 32'd1, "cont_frozen");
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0d, required %0d", e.name, g, e.exp);
      end
    end
  endtask

  task automatic test_collision();
    sb_t         e;
    logic [31:0] g;
    wr(2, 2, 32'd2);
    wr(2, 1, 32'h6);
    idle(2);
    wr(2, 0, 32'd0);  // lands on the timeout edge
    rd(2, 0, 32'd3, "collision_to_kept");
    wr(2, 0, 32'd0);  // no event on this edge
    rd(2, 0, 32'd2, "collision_clear");
    rd(2, 0, 32'd3, "collision_next_event");
    wr(2, 1, 32'h8);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0d, required %0d", e.name, g, e.exp);
      end
    end
  endtask

  task automatic test_mid_period();
    sb_t         e;
    logic [31:0] g;
    wr(3, 2, 32'd50);
    wr(3, 1, 32'h6);
    idle(10);
    wr(3, 2, 32'd100);  // sampled while count is 40
    idle(1);
    rd(3, 0, 32'd0, "midper_run_cleared");
    wr(3, 3, 32'd0);
    rd(3, 3, 32'd100, "midper_snap");
    rd(3, 2, 32'd100, "midper_period");
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0d, required %0d", e.name, g, e.exp);
      end
    end
  endtask

  task automatic test_pwm();
    sb_t         e;
    logic [31:0] g;
    int          hi;
    int          other;
    hi    = 0;
    other = 0;
    wr(0, 4, 32'd3);
`ifdef TIMER_PWM_EN
    rd(0, 4, 32'd3, "pwm_compare");
`else
    rd(0, 4, 32'd0, "pwm_compare_absent");
`endif
    wr(0, 2, 32'd9);
    wr(0, 1, 32'h6);
    idle(12);
    for (int i = 0; i < 30; i++) begin
      hi    += int'(pwm_out[0]);
      other += int'(pwm_out[3:1] != 3'b000);
      idle(1);
    end
    checks++;
`ifdef TIMER_PWM_EN
    if (hi != 9 || other != 0) begin
      errors++;
      $display("FAIL pwm_duty: high %0d of 30 (others %0d), required 9 (others 0)", hi, other);
    end
`else
    if (hi != 0 || other != 0) begin
      errors++;
      $display("FAIL pwm_tied: high %0d of 30 (others %0d), required 0", hi, other);
    end
`endif
    wr(0, 1, 32'h8);
    idle(2);
    checks++;
    if (pwm_out !== '0) begin
      errors++;
      $display("FAIL pwm_stopped: pwm=%b, required 0000", pwm_out);
    end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0d, required %0d", e.name, g, e.exp);
      end
    end
  endtask

  task automatic test_async_reset();
    sb_t         e;
    logic [31:0] g;
    wr(1, 2, 32'd2);
    wr(1, 1, 32'h7);
    idle(6);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre_irq: irq=%b, required 1", irq);
    end
    address    = ADDR_W'(8 + 2);
    chipselect = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (readdata !== 32'd2) begin
      errors++;
      $display("FAIL areset_pre_read: readdata=%0d, required 2", readdata);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (readdata !== 32'd0 || irq !== 1'b0 || irq_vec !== '0) begin
      errors++;
      $display("FAIL areset_immediate: readdata=%0d irq=%b irq_vec=%b, required 0",
               readdata, irq, irq_vec);
    end
    chipselect = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rd(1, 2, 32'd49999, "areset_period");
    rd(1, 0, 32'd0, "areset_status");
    rd(1, 1, 32'd0, "areset_control");
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0d, required %0d", e.name, g, e.exp);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_continuous();
    test_collision();
    test_mid_period();
    test_pwm();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
